// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_frame_ctrl : fetches an NxN frame into the convolutor, flags strided
//                   KxK window results with row/col/last tags
// Revision        : 1.0
// ----------------------------------------------------------------------------
module conv_frame_ctrl #(
  parameter int N          = 4,
  parameter int K_SIZE     = 3,
  parameter int STRIDE     = 1,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int CONV_LAT   = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [ADDR_WIDTH-1:0]                    base_addr,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     mem_en,
  output logic [ADDR_WIDTH-1:0]                    mem_addr,
  input  logic [DATA_WIDTH-1:0]                    mem_dout,
  output logic                                     conv_en,
  output logic [DATA_WIDTH-1:0]                    conv_data,
  input  logic [DATA_WIDTH-1:0]                    conv_result,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic                                     out_valid,
  output logic [$clog2((N-K_SIZE)/STRIDE+1):0]     out_row,
  output logic [$clog2((N-K_SIZE)/STRIDE+1):0]     out_col,
  output logic                                     out_last
);

  localparam int M    = (N - K_SIZE) / STRIDE + 1;
  localparam int OW   = $clog2(M) + 1;
  localparam int NPIX = N * N;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int SW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int DW   = $clog2(CONV_LAT + 1);

  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [CW-1:0] N_M1     = CW'(N - 1);
  localparam logic [CW-1:0] K_M1     = CW'(K_SIZE - 1);
  localparam logic [SW-1:0] S_M1     = SW'(STRIDE - 1);
  localparam logic [OW-1:0] M_CNT    = OW'(M);
  localparam logic [OW-1:0] M_M1     = OW'(M - 1);
  localparam logic [DW-1:0] LAT_END  = DW'(CONV_LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [PW-1:0]         p_q, p_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic                  conv_en_q, conv_en_d;
  logic [CW-1:0]         r_q, r_d, c_q, c_d;
  logic [SW-1:0]         rph_q, rph_d, cph_q, cph_d;
  logic [OW-1:0]         orow_q, orow_d, ocol_q, ocol_d;
  logic [CONV_LAT-1:0]   vld_q, vld_d, last_q, last_d;
  logic [OW-1:0]         row_q [CONV_LAT];
  logic [OW-1:0]         row_d [CONV_LAT];
  logic [OW-1:0]         col_q [CONV_LAT];
  logic [OW-1:0]         col_d [CONV_LAT];

  logic row_hit, col_hit, hit, hit_last;

  // Phase counters are zero exactly on stride-grid positions once past K-1
  assign row_hit  = (r_q >= K_M1) && (rph_q == '0) && (orow_q < M_CNT);
  assign col_hit  = (c_q >= K_M1) && (cph_q == '0) && (ocol_q < M_CNT);
  assign hit      = conv_en_q && row_hit && col_hit;
  assign hit_last = hit && (orow_q == M_M1) && (ocol_q == M_M1);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    p_d       = p_q;
    dcnt_d    = dcnt_q;
    conv_en_d = (state_q == S_FETCH);
    r_d       = r_q;
    c_d       = c_q;
    rph_d     = rph_q;
    cph_d     = cph_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          base_d  = base_addr;
          p_d     = '0;
        end
      end
      S_FETCH: begin
        if (p_q == LAST_PIX) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          p_d = p_q + PW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == LAT_END) state_d = S_DONE;
        else                   dcnt_d  = dcnt_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (conv_en_q) begin
      if (c_q == N_M1) begin
        c_d    = '0;
        cph_d  = '0;
        ocol_d = '0;
        if (r_q == N_M1) begin
          r_d    = '0;
          rph_d  = '0;
          orow_d = '0;
        end else begin
          r_d = r_q + CW'(1);
          if (r_q >= K_M1) begin
            if (rph_q == S_M1) begin
              rph_d  = '0;
              orow_d = orow_q + OW'(1);
            end else begin
              rph_d = rph_q + SW'(1);
            end
          end
        end
      end else begin
        c_d = c_q + CW'(1);
        if (c_q >= K_M1) begin
          if (cph_q == S_M1) begin
            cph_d  = '0;
            ocol_d = ocol_q + OW'(1);
          end else begin
            cph_d = cph_q + SW'(1);
          end
        end
      end
    end

    if ((state_q == S_IDLE) && start) begin
      r_d    = '0;
      c_d    = '0;
      rph_d  = '0;
      cph_d  = '0;
      orow_d = '0;
      ocol_d = '0;
    end

    // Tags are zeroed on non-hits so idle coordinates read as 0
    vld_d[0]  = hit;
    last_d[0] = hit_last;
    row_d[0]  = hit ? orow_q : '0;
    col_d[0]  = hit ? ocol_q : '0;
    for (int i = 1; i < CONV_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      row_d[i]  = row_q[i-1];
      col_d[i]  = col_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      p_q       <= '0;
      dcnt_q    <= '0;
      conv_en_q <= 1'b0;
      r_q       <= '0;
      c_q       <= '0;
      rph_q     <= '0;
      cph_q     <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      row_q     <= '{default: '0};
      col_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      p_q       <= p_d;
      dcnt_q    <= dcnt_d;
      conv_en_q <= conv_en_d;
      r_q       <= r_d;
      c_q       <= c_d;
      rph_q     <= rph_d;
      cph_q     <= cph_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_en    = (state_q == S_FETCH);
  assign mem_addr  = mem_en ? (base_q + ADDR_WIDTH'(p_q)) : '0;
  assign conv_en   = conv_en_q;
  assign conv_data = mem_dout;
  assign out_data  = conv_result;
  assign out_valid = vld_q[CONV_LAT-1];
  assign out_last  = last_q[CONV_LAT-1];
  assign out_row   = row_q[CONV_LAT-1];
  assign out_col   = col_q[CONV_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_frame_ctrl : three configurations checked against a frame-level model
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_conv_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] hsh(input int a);
    return 16'(a * 40503 + 4660);
  endfunction

  // Window rule in plain arithmetic: pixel p -> (hit, output row, output col)
  function automatic bit win(input int p, input int n, input int k, input int s,
                             output int orow, output int ocol);
    int r, c, m;
    r = p / n;
    c = p % n;
    m = (n - k) / s + 1;
    orow = (r - k + 1) / s;
    ocol = (c - k + 1) / s;
    return (r >= k - 1) && (c >= k - 1) && ((r - k + 1) % s == 0) &&
           ((c - k + 1) % s == 0) && (orow < m) && (ocol < m);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int N  = (g == 0) ? 4 : (g == 1) ? 8 : 3;
    localparam int K  = 3;
    localparam int S  = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int L  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int AW = (g == 0) ? 4 : 14;
    localparam int M  = (N - K) / S + 1;
    localparam int OW = $clog2(M) + 1;
    localparam int TD = N * N + 2 + L;
    localparam int LIT_CNT   = (g == 0) ? 4  : (g == 1) ? 9  : 1;
    localparam int LIT_FIRST = (g == 0) ? 13 : (g == 1) ? 22 : 14;
    localparam int LIT_LAST  = (g == 0) ? 18 : (g == 1) ? 58 : 14;
    localparam int LIT_DONE  = (g == 0) ? 19 : (g == 1) ? 68 : 15;

    logic          rst, start, busy, done, mem_en, conv_en, out_valid, out_last;
    logic [AW-1:0] base_addr, mem_addr;
    logic [15:0]   mem_dout, conv_data, conv_result, out_data;
    logic [OW-1:0] out_row, out_col;
    logic          fin;
    bit            lit_arm;

    int t0 = 0, fb = 0;
    bit act = 0, prev_rst = 0, lit_on = 0;
    int lit_t0 = 0, lit_cnt = 0, lit_first = 0, lit_last = 0, lit_done = 0;

    conv_frame_ctrl #(
      .N(N), .K_SIZE(K), .STRIDE(S), .DATA_WIDTH(16), .ADDR_WIDTH(AW), .CONV_LAT(L)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .conv_en(conv_en), .conv_data(conv_data),
      .conv_result(conv_result), .out_data(out_data), .out_valid(out_valid),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always @(posedge clk) mem_dout <= mem_en ? hsh(int'(mem_addr)) : 16'($urandom);

    initial begin
      conv_result = 16'($urandom);
      forever begin
        @(posedge clk);
        #1 conv_result = 16'($urandom);
      end
    end

    always @(negedge clk) begin
      int k, p, orw, ocl;
      bit h, eb, em, ec;
      if (cyc >= 1) begin
        k  = act ? cyc - t0 : -1;
        eb = act && k >= 1 && k <= TD;
        em = act && k >= 1 && k <= N * N;
        ec = act && k >= 2 && k <= N * N + 1;
        p  = k - 2 - L;
        h  = act && p >= 0 && p < N * N && win(p, N, K, S, orw, ocl);
        chk("busy", busy, eb);
        chk("done", done, act && k == TD);
        chk("mem_en", mem_en, em);
        chk("mem_addr", mem_addr, em ? (fb + k - 1) % (1 << AW) : 0);
        chk("conv_en", conv_en, ec);
        if (ec) chk("conv_data", conv_data, hsh((fb + k - 2) % (1 << AW)));
        chk("out_valid", out_valid, h);
        if (h) begin
          chk("out_row", out_row, orw);
          chk("out_col", out_col, ocl);
          chk("out_last", out_last, (orw == M - 1) && (ocl == M - 1));
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        if (prev_rst) begin
          chk("row_after_rst", out_row, 0);
          chk("col_after_rst", out_col, 0);
        end
        chk("out_data", out_data, conv_result);
        if (lit_on) begin
          if (out_valid) begin
            if (lit_cnt == 0) lit_first = cyc - lit_t0;
            lit_last = cyc - lit_t0;
            lit_cnt++;
          end
          if (done) begin
            lit_done = cyc - lit_t0;
            lit_on   = 0;
          end
        end
      end
      if (rst) begin
        act = 0;
      end else if (start && !(act && cyc - t0 <= TD)) begin
        act = 1;
        t0  = cyc;
        fb  = int'(base_addr);
        if (lit_arm) begin
          lit_on  = 1;
          lit_t0  = cyc;
          lit_cnt = 0;
        end
      end
      prev_rst = rst;
    end

    initial begin
      int n, hc, a, b;
      rst = 1'b1; start = 1'b0; base_addr = '0; lit_arm = 0; fin = 1'b0;
      hc = 0;
      for (int q = 0; q < N * N; q++) if (win(q, N, K, S, a, b)) hc++;
      chk("model_hits", hc, LIT_CNT);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int rep = 0; rep < 2; rep++) begin
        // Reference frame at base 0 with hand-derived timing
        start = 1'b1; base_addr = '0; lit_arm = 1;
        @(posedge clk); #1 start = 1'b0; lit_arm = 0;
        n = 0;
        while (!done && n < 400) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("lit_count", lit_cnt, LIT_CNT);
        chk("lit_first", lit_first, LIT_FIRST);
        chk("lit_last", lit_last, LIT_LAST);
        chk("lit_done", lit_done, LIT_DONE);
        if (rep == 0) begin
          // Back-to-back frame, with a start during busy that must be ignored
          start = 1'b1; base_addr = AW'((g == 0) ? 'hC : 'h100);
          @(posedge clk); #1 start = 1'b0;
          repeat (5) @(posedge clk);
          #1 start = 1'b1; base_addr = AW'(3);
          @(posedge clk); #1 start = 1'b0;
          n = 0;
          while (!done && n < 400) begin @(negedge clk); n++; end
          chk("done_seen2", done, 1);
          @(posedge clk); #1;
          // Reset landing in the middle of FETCH
          start = 1'b1; base_addr = AW'(5);
          @(posedge clk); #1 start = 1'b0;
          repeat (5) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk); #1 rst = 1'b0;
          repeat (4) @(posedge clk);
          #1;
        end
      end

      for (int i = 0; i < 1500; i++) begin
        @(posedge clk);
        #1;
        start     = ($urandom_range(0, 9) == 0);
        base_addr = AW'($urandom);
        rst       = ($urandom_range(0, 399) == 0);
      end
      start = 1'b0; rst = 1'b0;
      repeat (TD + 5) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int n;
    bit all_fin;
    n = 0;
    all_fin = 0;
    while (!all_fin && n < 20000) begin
      @(posedge clk);
      n++;
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
    end
    chk("bench_finished", all_fin, 1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
`default_nettype wire
